// File: rtl/gauss_stream_ctrl_pkg.sv
// Shared definitions for the Gaussian stream controller.
//   - state_e   : controller FSM states
//   - PIX_W     : pixel width in bits
//   - SUM_W     : width of the weighted 3x3 sum (max 16*255 = 4080)
//   - KERNEL_W  : 3x3 kernel weights, row-major, element index r*3+c
//   - weighted(): one pixel times one weight, widened to the sum width
package gauss_stream_ctrl_pkg;

    localparam int PIX_W = 8;
    localparam int SUM_W = 12;
    localparam int WT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // 1 2 1 / 2 4 2 / 1 2 1 ; weights sum to 16, so sum[11:4] is the mean
    localparam logic [8:0][WT_W-1:0] KERNEL_W = {
        3'd1, 3'd2, 3'd1,
        3'd2, 3'd4, 3'd2,
        3'd1, 3'd2, 3'd1
    };

    function automatic logic [SUM_W-1:0] weighted(input logic [PIX_W-1:0] p,
                                                  input logic [WT_W-1:0]  w);
        return SUM_W'(p) * SUM_W'(w);
    endfunction

endpackage

// File: rtl/gauss_stream_ctrl_kernel.sv
// gauss_kernel: 3x3 weighted sum with a registered, back-pressured output.
// Ports:
//   clk, rst   clock / async active-high reset
//   load_i     capture a new result from win_i (takes priority over pop_i)
//   last_i     frame-final marker carried alongside the result
//   pop_i      downstream ready; clears the output slot when nothing loads
//   win_i      3x3 window, element (r,c) at bits [(r*3+c)*PIX_W +: PIX_W]
//   valid_o    output slot holds a result
//   pixel_o    blurred pixel, sum truncated to its top PIX_W bits
//   last_o     result is the final pixel of the frame
module gauss_kernel
    import gauss_stream_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 last_i,
    input  logic                 pop_i,
    input  logic [9*PIX_W-1:0]   win_i,
    output logic                 valid_o,
    output logic [PIX_W-1:0]     pixel_o,
    output logic                 last_o
);

    logic [SUM_W-1:0] sum_d;
    logic             valid_q;
    logic [PIX_W-1:0] pixel_q;
    logic             last_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + weighted(win_i[k*PIX_W +: PIX_W], KERNEL_W[k]);
        end
    end

    // The controller only loads when the slot is empty or being popped,
    // so a load never overwrites an unconsumed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pixel_q <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pixel_q <= sum_d[SUM_W-1 -: PIX_W];
            last_q  <= last_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pixel_o = pixel_q;
    assign last_o  = last_q;

endmodule

// File: rtl/gauss_stream_ctrl.sv
// gauss_stream_ctrl: streams a raster IMG_W x IMG_H frame through a 3x3
// Gaussian blur and emits the (IMG_W-2) x (IMG_H-2) interior in raster order.
// Ports:
//   clk, rst          clock / async active-high reset
//   start             one-cycle frame request, honoured only in IDLE
//   s_valid/s_ready   input pixel handshake, s_pixel raster order
//   m_valid/m_ready   output handshake, m_pixel blurred, m_last on final beat
//   busy              high in RUN or FLUSH
//   done              one-cycle pulse after the final output is taken
module gauss_stream_ctrl
    import gauss_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic            accept;
    logic            at_col_end;
    logic            frame_end;
    logic            issue;

    // lb0 holds row-1, lb1 holds row-2, both indexed by column
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

    assign accept     = s_valid && s_ready;
    assign at_col_end = (col_q == COL_MAX);
    assign frame_end  = at_col_end && (row_q == ROW_MAX);
    // Line-buffer and window contents are only trusted once two full rows
    // and two columns of the current row are in, so they need no reset.
    assign issue      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && frame_end) state_d = ST_FLUSH;
            ST_FLUSH: if (m_valid && m_ready && m_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_ready = (state_q == ST_RUN) && (!m_valid || m_ready);
        busy    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done    = (state_q == ST_DONE);
    end

    // ---------------- raster counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == ST_IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (at_col_end) begin
                col_d = '0;
                if (row_q != ROW_MAX) row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- window ----------------
    // win_d is the window including the column being accepted right now;
    // feeding it straight to the kernel gives one-cycle latency to m_valid.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_q[col_q];
        win_d[1][2] = lb0_q[col_q];
        win_d[2][2] = s_pixel;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q        <= win_d;
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= s_pixel;
        end
    end

    gauss_kernel u_kernel (
        .clk     (clk),
        .rst     (rst),
        .load_i  (issue),
        .last_i  (frame_end),
        .pop_i   (m_ready),
        .win_i   (win_d),
        .valid_o (m_valid),
        .pixel_o (m_pixel),
        .last_o  (m_last)
    );

endmodule

// File: tb/tb_gauss_stream_ctrl.sv
module tb_gauss_stream_ctrl;
    import gauss_stream_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, s_valid, m_ready;
    logic [7:0] s_pixel;
    logic [1:0] sel;
    logic [2:0] start_v, s_ready_v, m_valid_v, m_last_v, busy_v, done_v;
    logic [7:0] m_pixel_v [3];

    assign start_v[0] = start && (sel == 2'd0);
    assign start_v[1] = start && (sel == 2'd1);
    assign start_v[2] = start && (sel == 2'd2);

    gauss_stream_ctrl #(.IMG_W(3), .IMG_H(3)) u3 (
        .clk(clk), .rst(rst), .start(start_v[0]), .s_valid(s_valid),
        .s_ready(s_ready_v[0]), .s_pixel(s_pixel), .m_valid(m_valid_v[0]),
        .m_ready(m_ready), .m_pixel(m_pixel_v[0]), .m_last(m_last_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    gauss_stream_ctrl #(.IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .s_valid(s_valid),
        .s_ready(s_ready_v[1]), .s_pixel(s_pixel), .m_valid(m_valid_v[1]),
        .m_ready(m_ready), .m_pixel(m_pixel_v[1]), .m_last(m_last_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    gauss_stream_ctrl #(.IMG_W(8), .IMG_H(8)) u8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .s_valid(s_valid),
        .s_ready(s_ready_v[2]), .s_pixel(s_pixel), .m_valid(m_valid_v[2]),
        .m_ready(m_ready), .m_pixel(m_pixel_v[2]), .m_last(m_last_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    logic       o_sready, o_mvalid, o_mlast, o_busy, o_done;
    logic [7:0] o_mpix;

    always_comb begin
        o_sready = 1'b0; o_mvalid = 1'b0; o_mlast = 1'b0;
        o_busy   = 1'b0; o_done   = 1'b0; o_mpix  = 8'h00;
        case (sel)
            2'd0: begin o_sready = s_ready_v[0]; o_mvalid = m_valid_v[0]; o_mlast = m_last_v[0];
                        o_busy = busy_v[0]; o_done = done_v[0]; o_mpix = m_pixel_v[0]; end
            2'd1: begin o_sready = s_ready_v[1]; o_mvalid = m_valid_v[1]; o_mlast = m_last_v[1];
                        o_busy = busy_v[1]; o_done = done_v[1]; o_mpix = m_pixel_v[1]; end
            2'd2: begin o_sready = s_ready_v[2]; o_mvalid = m_valid_v[2]; o_mlast = m_last_v[2];
                        o_busy = busy_v[2]; o_done = done_v[2]; o_mpix = m_pixel_v[2]; end
            default: ;
        endcase
    end

    int         w, h;
    logic [7:0] img [64];
    logic [7:0] got_p [$];
    logic       got_l [$];
    logic [7:0] ref_p [$];
    int done_cnt, stab_err, first_out, win_cyc, timed_out;
    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Independent reference: blurred value centred on (r,c) of img.
    function automatic logic [7:0] model(input int r, input int c);
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(img[(r+dr)*w + c + dc]) * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        return 8'(s >> 4);
    endfunction

    function automatic int model_errs();
        int e, k;
        e = 0;
        k = 0;
        for (int r = 1; r < h-1; r++)
            for (int c = 1; c < w-1; c++) begin
                if (k >= got_p.size() || got_p[k] !== model(r, c)) e++;
                k++;
            end
        return e;
    endfunction

    function automatic int last_count();
        int n;
        n = 0;
        foreach (got_l[i]) if (got_l[i] === 1'b1) n++;
        return n;
    endfunction

    // Drives one frame into the selected DUT while monitoring its output.
    // Called at posedge+#1. abort_after>0 returns right after that many
    // pixels are accepted; start_at>=0 pulses start again in that cycle.
    task automatic run_frame(input int stall, input int gap,
                             input int abort_after, input int start_at);
        int idx, cyc, post;
        logic prev_stall, prev_l, seen_done, acc;
        logic [7:0] prev_p;
        idx = 0; cyc = 0; post = 0;
        prev_stall = 1'b0; prev_l = 1'b0; prev_p = 8'h00; seen_done = 1'b0;
        got_p.delete(); got_l.delete();
        done_cnt = 0; stab_err = 0; first_out = -1; win_cyc = -1; timed_out = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (1) begin
            if (cyc >= 3000) begin timed_out = 1; break; end
            m_ready = (stall != 0) ? ((cyc % 3) == 0) : 1'b1;
            if (idx < w*h && (gap == 0 || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1; s_pixel = img[idx];
            end else begin
                s_valid = 1'b0; s_pixel = 8'h00;
            end
            start = (cyc == start_at);
            #1;
            if (prev_stall && (!o_mvalid || o_mpix !== prev_p || o_mlast !== prev_l)) stab_err++;
            if (o_mvalid && first_out < 0) first_out = cyc;
            if (o_mvalid && m_ready) begin
                got_p.push_back(o_mpix);
                got_l.push_back(o_mlast);
            end
            prev_stall = o_mvalid && !m_ready;
            prev_p = o_mpix;
            prev_l = o_mlast;
            if (o_done) begin done_cnt++; seen_done = 1'b1; end
            acc = s_valid && o_sready;
            if (acc && idx == 2*w + 2) win_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (abort_after > 0 && idx == abort_after) break;
            if (seen_done) begin post++; if (post > 4) break; end
        end
        s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        sel = 2'd2; rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixel = 8'h00; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({o_mvalid, o_mlast, o_sready, o_busy, o_done} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {o_mvalid, o_mlast, o_sready, o_busy, o_done});
        else pass_cnt++;
        chk_cnt++;
        if (o_mpix !== 8'h00) $display("FAIL reset_pixel: got %0d want 0", o_mpix);
        else pass_cnt++;
        chk_cnt++;
        if (u8.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", u8.state_q, ST_IDLE);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (o_sready !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL idle_after_reset: got sready=%b busy=%b want 0 0", o_sready, o_busy);
        else pass_cnt++;
    endtask

    task automatic test_flat();
        int bad;
        sel = 2'd1; w = 4; h = 4;
        foreach (img[i]) img[i] = 8'd100;
        run_frame(0, 0, -1, -1);
        chk_cnt++;
        if (timed_out != 0 || got_p.size() != 4)
            $display("FAIL flat_count: got %0d outputs (timeout=%0d) want 4", got_p.size(), timed_out);
        else pass_cnt++;
        bad = 0;
        foreach (got_p[i]) if (got_p[i] !== 8'd100) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL flat_value: got %0d wrong pixels want 0 (expected 100 each)", bad);
        else pass_cnt++;
        chk_cnt++;
        if (last_count() != 1 || got_l[3] !== 1'b1)
            $display("FAIL flat_last: got %0d last flags want 1 on output 4", last_count());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL flat_done: got %0d pulses want 1", done_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (first_out != win_cyc + 1)
            $display("FAIL flat_latency: got m_valid at cycle %0d want %0d", first_out, win_cyc + 1);
        else pass_cnt++;
    endtask

    task automatic test_center();
        sel = 2'd0; w = 3; h = 3;
        foreach (img[i]) img[i] = 8'd0;
        img[4] = 8'd160;
        run_frame(0, 0, -1, -1);
        chk_cnt++;
        if (got_p.size() != 1) $display("FAIL center_count: got %0d want 1", got_p.size());
        else pass_cnt++;
        chk_cnt++;
        if (got_p[0] !== 8'd40) $display("FAIL center_value: got %0d want 40", got_p[0]);
        else pass_cnt++;
        chk_cnt++;
        if (got_l[0] !== 1'b1) $display("FAIL center_last: got %b want 1", got_l[0]);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL center_done: got %0d want 1", done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        int bad;
        sel = 2'd1; w = 4; h = 4;
        foreach (img[i]) img[i] = 8'd255;
        run_frame(0, 0, -1, -1);
        chk_cnt++;
        if (got_p.size() != 4) $display("FAIL sat_count: got %0d want 4", got_p.size());
        else pass_cnt++;
        bad = 0;
        foreach (got_p[i]) if (got_p[i] !== 8'd255) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL sat_value: got %0d wrong pixels want 0 (expected 255 each)", bad);
        else pass_cnt++;
    endtask

    task automatic test_ramp_stall();
        int bad;
        sel = 2'd2; w = 8; h = 8;
        foreach (img[i]) img[i] = 8'((i * 7 + 3) & 255);
        run_frame(0, 0, -1, -1);
        chk_cnt++;
        if (got_p.size() != 36) $display("FAIL ramp_ref_count: got %0d want 36", got_p.size());
        else pass_cnt++;
        chk_cnt++;
        if (model_errs() != 0) $display("FAIL ramp_ref_value: got %0d errors want 0", model_errs());
        else pass_cnt++;
        ref_p = got_p;
        run_frame(1, 1, -1, -1);
        chk_cnt++;
        if (timed_out != 0 || got_p.size() != 36)
            $display("FAIL stall_count: got %0d (timeout=%0d) want 36", got_p.size(), timed_out);
        else pass_cnt++;
        bad = 0;
        foreach (ref_p[i]) if (i >= got_p.size() || got_p[i] !== ref_p[i]) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL stall_vs_ref: got %0d differences want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (model_errs() != 0) $display("FAIL stall_value: got %0d errors want 0", model_errs());
        else pass_cnt++;
        chk_cnt++;
        if (stab_err != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stab_err);
        else pass_cnt++;
        chk_cnt++;
        if (last_count() != 1 || got_l[35] !== 1'b1)
            $display("FAIL stall_last: got %0d last flags want 1 on output 36", last_count());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL stall_done: got %0d want 1", done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        sel = 2'd2; w = 8; h = 8;
        foreach (img[i]) img[i] = 8'((i * 11 + 5) & 255);
        run_frame(0, 0, 10, -1);
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (o_mvalid !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL abort_outputs: got mvalid=%b busy=%b want 0 0", o_mvalid, o_busy);
        else pass_cnt++;
        chk_cnt++;
        if (u8.state_q !== ST_IDLE) $display("FAIL abort_state: got %0d want %0d", u8.state_q, ST_IDLE);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s_valid = 1'b1; s_pixel = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (o_mvalid !== 1'b0 || o_sready !== 1'b0)
            $display("FAIL abort_quiet: got mvalid=%b sready=%b want 0 0", o_mvalid, o_sready);
        else pass_cnt++;
        s_valid = 1'b0;
        foreach (img[i]) img[i] = 8'(255 - i * 3);
        run_frame(0, 0, -1, -1);
        chk_cnt++;
        if (got_p.size() != 36) $display("FAIL restart_count: got %0d want 36", got_p.size());
        else pass_cnt++;
        chk_cnt++;
        if (model_errs() != 0) $display("FAIL restart_value: got %0d errors want 0", model_errs());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL restart_done: got %0d want 1", done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_start_in_run();
        sel = 2'd1; w = 4; h = 4;
        foreach (img[i]) img[i] = 8'((i * 13) & 255);
        run_frame(0, 0, -1, 5);
        chk_cnt++;
        if (got_p.size() != 4) $display("FAIL restart_ignored_count: got %0d want 4", got_p.size());
        else pass_cnt++;
        chk_cnt++;
        if (model_errs() != 0) $display("FAIL restart_ignored_value: got %0d errors want 0", model_errs());
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL restart_ignored_done: got %0d want 1", done_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_center();
        test_saturate();
        test_ramp_stall();
        test_reset_mid();
        test_start_in_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
